// File: rtl/cic_comp_fir_pkg.sv
// cic_comp_fir_pkg: shared constants, compensation coefficients and FSM states
// for the CIC compensation FIR. Coefficients are Q1.17, symmetric, and sum to
// 2^17 (unity DC gain).
package cic_comp_fir_pkg;

  localparam int unsigned NTAPS      = 21;
  localparam int unsigned COEF_WIDTH = 18;
  localparam int unsigned COEF_FRAC  = 17;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  // Negative side lobes give sum|c| > 2^17, so full-scale inputs can clip.
  localparam coef_t COEFS [NTAPS] = '{
    -18'sd100,  -18'sd200,   18'sd150,   18'sd500,  -18'sd300,
    -18'sd1200,  18'sd600,   18'sd3000, -18'sd2000,  18'sd20000,
     18'sd90172,
     18'sd20000, -18'sd2000,  18'sd3000,  18'sd600, -18'sd1200,
    -18'sd300,   18'sd500,   18'sd150,  -18'sd200,  -18'sd100
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    RND  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/cic_comp_fir_lane.sv
// cic_comp_fir_lane: one lane of the compensation FIR -- circular sample
// history, serial multiply-accumulate, round-half-up and saturation.
// Optional saturation flags are enabled by CIC_COMP_FIR_OFLOW_FLAGS_EN.
module cic_comp_fir_lane #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NTAPS      = cic_comp_fir_pkg::NTAPS,
  parameter int unsigned COEF_WIDTH = cic_comp_fir_pkg::COEF_WIDTH
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       accept,
  input  logic                       mac_en,
  input  logic                       rnd_en,
  input  logic                       out_en,
  input  logic [$clog2(NTAPS)-1:0]   tap,
  input  logic signed [WIDTH-1:0]    sample_in,
  output logic signed [WIDTH-1:0]    sample_out,
  output logic                       pos_oflow,
  output logic                       neg_oflow
);
  import cic_comp_fir_pkg::*;

  localparam int unsigned PTR_W  = $clog2(NTAPS);
  localparam int unsigned PROD_W = WIDTH + COEF_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NTAPS);

  localparam logic [PTR_W-1:0]        LAST     = PTR_W'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(2 ** (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  logic signed [WIDTH-1:0]      hist [NTAPS];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic signed [ACC_W-1:0]      acc;
  logic signed [COEF_WIDTH-1:0] coef_c;
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [ACC_W-1:0]      rnd_c;
  logic signed [WIDTH-1:0]      sat_c;
  logic                         pos_c;
  logic                         neg_c;
  logic signed [WIDTH-1:0]      rnd_q;

  // Tap product and rounded/saturated view of the accumulator.
  always_comb begin
    coef_c = COEF_WIDTH'(COEFS[tap]);
    prod_c = hist[rd_ptr] * coef_c;
    rnd_c  = (acc + HALF) >>> COEF_FRAC;
    pos_c  = (rnd_c > SAT_MAX);
    neg_c  = (rnd_c < SAT_MIN);
    if (pos_c) begin
      sat_c = SAT_MAX[WIDTH-1:0];
    end else if (neg_c) begin
      sat_c = SAT_MIN[WIDTH-1:0];
    end else begin
      sat_c = rnd_c[WIDTH-1:0];
    end
  end

  // History write, newest-to-oldest MAC walk, round capture and output hold.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        hist[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      acc        <= '0;
      rnd_q      <= '0;
      sample_out <= '0;
    end else begin
      if (accept) begin
        hist[wr_ptr] <= sample_in;
        rd_ptr       <= wr_ptr;
        wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        acc          <= '0;
      end
      if (mac_en) begin
        acc    <= acc + ACC_W'(prod_c);
        rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
      end
      if (rnd_en) begin
        rnd_q <= sat_c;
      end
      if (out_en) begin
        sample_out <= rnd_q;
      end
    end
  end

`ifdef CIC_COMP_FIR_OFLOW_FLAGS_EN
  logic pos_q;
  logic neg_q;

  // Clip direction captured at rounding, presented only alongside the output.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
      pos_oflow <= 1'b0;
      neg_oflow <= 1'b0;
    end else begin
      if (rnd_en) begin
        pos_q <= pos_c;
        neg_q <= neg_c;
      end
      pos_oflow <= out_en & pos_q;
      neg_oflow <= out_en & neg_q;
    end
  end
`else
  assign pos_oflow = 1'b0;
  assign neg_oflow = 1'b0;
`endif

endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: I/Q CIC compensation FIR. One shared FSM sequences two
// identical lanes: accept, NTAPS MAC cycles, round, output.
// Saturation flag outputs are live only with CIC_COMP_FIR_OFLOW_FLAGS_EN.
module cic_comp_fir #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NTAPS      = cic_comp_fir_pkg::NTAPS,
  parameter int unsigned COEF_WIDTH = cic_comp_fir_pkg::COEF_WIDTH
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_inph,
  input  logic signed [WIDTH-1:0] i_quad,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [WIDTH-1:0] o_inph,
  output logic signed [WIDTH-1:0] o_quad,
  output logic                    o_valid,
  output logic                    o_inph_pos_oflow,
  output logic                    o_inph_neg_oflow,
  output logic                    o_quad_pos_oflow,
  output logic                    o_quad_neg_oflow
);
  import cic_comp_fir_pkg::*;

  localparam int unsigned TAP_W = $clog2(NTAPS);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

  state_t           state_q;
  state_t           state_c;
  logic [TAP_W-1:0] tap_q;
  logic             accept_c;
  logic             mac_en_c;
  logic             rnd_en_c;
  logic             out_en_c;

  assign accept_c = i_valid & o_ready;

  // State register, tap counter and registered handshake outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_c;
      if (accept_c) begin
        tap_q <= '0;
      end else if (mac_en_c) begin
        tap_q <= tap_q + 1'b1;
      end
      o_ready <= (state_c == IDLE) || (state_c == OUT);
      o_valid <= out_en_c;
    end
  end

  // Next-state and lane strobes.
  always_comb begin
    state_c  = state_q;
    mac_en_c = 1'b0;
    rnd_en_c = 1'b0;
    out_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) state_c = MAC;
      end
      MAC: begin
        mac_en_c = 1'b1;
        if (tap_q == LAST_TAP) state_c = RND;
      end
      RND: begin
        rnd_en_c = 1'b1;
        state_c  = OUT;
      end
      OUT: begin
        out_en_c = 1'b1;
        state_c  = accept_c ? MAC : IDLE;
      end
      default: state_c = IDLE;
    endcase
  end

  cic_comp_fir_lane #(
    .WIDTH      (WIDTH),
    .NTAPS      (NTAPS),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_lane_inph (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .accept     (accept_c),
    .mac_en     (mac_en_c),
    .rnd_en     (rnd_en_c),
    .out_en     (out_en_c),
    .tap        (tap_q),
    .sample_in  (i_inph),
    .sample_out (o_inph),
    .pos_oflow  (o_inph_pos_oflow),
    .neg_oflow  (o_inph_neg_oflow)
  );

  cic_comp_fir_lane #(
    .WIDTH      (WIDTH),
    .NTAPS      (NTAPS),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_lane_quad (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .accept     (accept_c),
    .mac_en     (mac_en_c),
    .rnd_en     (rnd_en_c),
    .out_en     (out_en_c),
    .tap        (tap_q),
    .sample_in  (i_quad),
    .sample_out (o_quad),
    .pos_oflow  (o_quad_pos_oflow),
    .neg_oflow  (o_quad_neg_oflow)
  );

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed self-checking bench for cic_comp_fir.
// Flag expectations follow CIC_COMP_FIR_OFLOW_FLAGS_EN.
module tb_cic_comp_fir;

  localparam int W   = 16;
  localparam int N   = 21;
  localparam int LAT = N + 2;

  logic                i_clock = 1'b0;
  logic                i_reset;
  logic signed [W-1:0] i_inph;
  logic signed [W-1:0] i_quad;
  logic                i_valid;
  logic                o_ready;
  logic signed [W-1:0] o_inph;
  logic signed [W-1:0] o_quad;
  logic                o_valid;
  logic                o_inph_pos_oflow;
  logic                o_inph_neg_oflow;
  logic                o_quad_pos_oflow;
  logic                o_quad_neg_oflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // round(0x4000 * c[k] / 2^17), hand-computed from the coefficient set.
  int imp_exp [N] = '{-12, -25, 19, 63, -37, -150, 75, 375, -250, 2500, 11272,
                      2500, -250, 375, 75, -150, -37, 63, 19, -25, -12};
  // sign(c[k])
  int sgn [N] = '{-1, -1, 1, 1, -1, -1, 1, 1, -1, 1, 1,
                  1, -1, 1, 1, -1, -1, 1, 1, -1, -1};

  always #5 i_clock = ~i_clock;

  cic_comp_fir #(
    .WIDTH      (W),
    .NTAPS      (N),
    .COEF_WIDTH (18)
  ) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_inph           (i_inph),
    .i_quad           (i_quad),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .o_inph           (o_inph),
    .o_quad           (o_quad),
    .o_valid          (o_valid),
    .o_inph_pos_oflow (o_inph_pos_oflow),
    .o_inph_neg_oflow (o_inph_neg_oflow),
    .o_quad_pos_oflow (o_quad_pos_oflow),
    .o_quad_neg_oflow (o_quad_neg_oflow)
  );

  function automatic logic [3:0] flags();
    return {o_inph_pos_oflow, o_inph_neg_oflow, o_quad_pos_oflow, o_quad_neg_oflow};
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push one sample, wait (bounded) for its output, return result and latency.
  task automatic xact(input logic signed [W-1:0] xi, input logic signed [W-1:0] xq,
                      output logic signed [W-1:0] yi, output logic signed [W-1:0] yq,
                      output logic [3:0] fl, output int lat);
    int guard;
    @(negedge i_clock);
    guard = 0;
    while (!o_ready && guard < 100) begin
      @(negedge i_clock);
      guard++;
    end
    i_valid = 1'b1;
    i_inph  = xi;
    i_quad  = xq;
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(posedge i_clock);
      lat++;
      #1;
      if (o_valid) break;
    end
    yi = o_inph;
    yq = o_quad;
    fl = flags();
  endtask

  task automatic run_impulse(input string tag);
    logic signed [W-1:0] yi, yq;
    logic [3:0]          fl;
    int                  lat;
    for (int k = 0; k < N; k++) begin
      xact((k == 0) ? 16'sh4000 : 16'sh0000, 16'sh0000, yi, yq, fl, lat);
      chk($sformatf("%s_lat[%0d]", tag, k), lat, LAT);
      chk($sformatf("%s_i[%0d]", tag, k), yi, imp_exp[k]);
      chk($sformatf("%s_q[%0d]", tag, k), yq, 0);
      chk($sformatf("%s_flags[%0d]", tag, k), fl, 0);
    end
  endtask

  initial begin
    logic signed [W-1:0] yi, yq;
    logic [3:0]          fl;
    int                  lat;
    int                  rdy;
    int                  seen;
    int                  acc_e [$];
    int                  out_e [$];
    longint              v;

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_inph  = '0;
    i_quad  = '0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;

    // Reset state
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_inph", o_inph, 0);
    chk("rst_quad", o_quad, 0);
    chk("rst_flags", flags(), 0);

    // Impulse response
    run_impulse("imp");

    // DC: settles to unity gain once the window is full
    for (int j = 0; j < 30; j++) begin
      xact(16'sd1000, -16'sd1000, yi, yq, fl, lat);
      chk($sformatf("dc_lat[%0d]", j), lat, LAT);
      if (j >= 20) begin
        v = (yi >= 999 && yi <= 1001) ? 64'sd1000 : longint'(yi);
        chk($sformatf("dc_i[%0d]", j), v, 1000);
        v = (yq >= -1001 && yq <= -999) ? -64'sd1000 : longint'(yq);
        chk($sformatf("dc_q[%0d]", j), v, -1000);
        chk($sformatf("dc_flags[%0d]", j), fl, 0);
      end
    end

    // Saturation: full-scale inputs sign-matched to the taps (Q inverted)
    for (int j = 0; j < N; j++) begin
      xact((sgn[j] > 0) ? 16'sh7FFF : -16'sh7FFF,
           (sgn[j] > 0) ? -16'sh7FFF : 16'sh7FFF, yi, yq, fl, lat);
    end
    chk("sat_lat", lat, LAT);
    chk("sat_i", yi, 32767);
    chk("sat_q", yq, -32768);
`ifdef CIC_COMP_FIR_OFLOW_FLAGS_EN
    chk("sat_flags", fl, 4'b1001);
`else
    chk("sat_flags", fl, 4'b0000);
`endif
    repeat (3) @(posedge i_clock);
    #1;
    chk("hold_i", o_inph, 32767);
    chk("hold_q", o_quad, -32768);
    chk("hold_valid", o_valid, 0);
    chk("hold_flags", flags(), 0);

    // Back-pressure: i_valid held high for 100 cycles
    @(negedge i_clock);
    i_valid = 1'b1;
    i_inph  = 16'sd5;
    i_quad  = -16'sd5;
    for (int c = 0; c < 130; c++) begin
      if (c == 100) i_valid = 1'b0;
      rdy = (o_ready && i_valid) ? 1 : 0;
      @(posedge i_clock);
      #1;
      if (rdy != 0) acc_e.push_back(c);
      if (o_valid) out_e.push_back(c);
      @(negedge i_clock);
    end
    chk("bp_accepts", acc_e.size(), 5);
    chk("bp_outputs", out_e.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < acc_e.size()) chk($sformatf("bp_acc_edge[%0d]", i), acc_e[i], i * LAT);
      if (i < out_e.size()) chk($sformatf("bp_out_edge[%0d]", i), out_e[i], i * LAT + LAT);
    end

    // Mid-operation reset 5 cycles into MAC
    @(negedge i_clock);
    i_valid = 1'b1;
    i_inph  = 16'sh4000;
    i_quad  = 16'sh0000;
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    i_inph  = '0;
    seen = 0;
    repeat (5) begin
      @(posedge i_clock);
      #1;
      if (o_valid) seen++;
    end
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_inph", o_inph, 0);
    @(negedge i_clock);
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
    chk("mrst_ready", o_ready, 1);
    for (int c = 0; c < 40; c++) begin
      if (o_valid) seen++;
      @(posedge i_clock);
      #1;
    end
    chk("mrst_no_valid", seen, 0);
    run_impulse("imp2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
